bcd_to_bin_year: RTL and testbench

//  Converts a four-digit BCD year (user entry from the set-time digit editor) into the
//  12-bit binary year consumed by the calendar counter. It is the inverse path of the

---
 rtl/bcd_to_bin_year.sv | 114 +++++++++++
 tb/tb_bcd_to_bin_year.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_year.sv
// Four-digit BCD year to 12-bit binary, one digit per cycle, with range check.
// Define BCD_YEAR_CLAMP_EN to clamp out-of-range years instead of flagging err.
module bcd_to_bin_year #(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 3999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  d_thou,
  input  logic [3:0]  d_hund,
  input  logic [3:0]  d_tens,
  input  logic [3:0]  d_ones,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] year,
  output logic        err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends combinationally on ready on either side.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [13:0] MIN14 = 14'(YEAR_MIN);
  localparam logic [13:0] MAX14 = 14'(YEAR_MAX);

  logic [1:0]  state;
  logic [15:0] digits;
  logic [13:0] acc;
  logic [1:0]  idx;
  logic        bad_digit;
  logic [3:0]  cur_digit;
  logic [13:0] acc_next;
  logic        below;
  logic        above;

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      2'd0:    cur_digit = digits[15:12];
      2'd1:    cur_digit = digits[11:8];
      2'd2:    cur_digit = digits[7:4];
      default: cur_digit = digits[3:0];
    endcase
  end

  // acc*10 built from shifts; with legal digits acc never exceeds 9999.
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, cur_digit};
  assign below    = (acc < MIN14);
  assign above    = (acc > MAX14);
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      digits    <= 16'd0;
      acc       <= 14'd0;
      idx       <= 2'd0;
      bad_digit <= 1'b0;
      out_valid <= 1'b0;
      year      <= 12'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            digits    <= {d_thou, d_hund, d_tens, d_ones};
            acc       <= 14'd0;
            idx       <= 2'd0;
            bad_digit <= (d_thou > 4'd9) || (d_hund > 4'd9) ||
                         (d_tens > 4'd9) || (d_ones > 4'd9);
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_RESULT;
        end
        S_RESULT: begin
          out_valid <= 1'b1;
          state     <= S_HOLD;
          if (bad_digit) begin
            year <= 12'd0;
            err  <= 1'b1;
          end else if (below || above) begin
`ifdef BCD_YEAR_CLAMP_EN
            year <= below ? 12'(YEAR_MIN) : 12'(YEAR_MAX);
            err  <= 1'b0;
`else
            year <= 12'd0;
            err  <= 1'b1;
`endif
          end else begin
            year <= acc[11:0];
            err  <= 1'b0;
          end
        end
        default: begin
          // Result is held until the consumer takes it; year/err persist afterwards.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_year.sv
// Bench for bcd_to_bin_year: directed vector table, reset-abort sequence, random years.
module tb_bcd_to_bin_year;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  d_thou, d_hund, d_tens, d_ones;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] year;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [12:0] exp_q[$];

  bcd_to_bin_year dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d_thou(d_thou), .d_hund(d_hund), .d_tens(d_tens), .d_ones(d_ones),
    .out_valid(out_valid), .out_ready(out_ready), .year(year), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    int          hold;
    logic [11:0] y;
    logic        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the digits, then the year rules.
  function automatic logic [12:0] ref_year(input logic [15:0] d);
    int v;
    if (d[15:12] > 9 || d[11:8] > 9 || d[7:4] > 9 || d[3:0] > 9) return {12'd0, 1'b1};
    v = 1000 * d[15:12] + 100 * d[11:8] + 10 * d[7:4] + d[3:0];
`ifdef BCD_YEAR_CLAMP_EN
    if (v < 2000) return {12'd2000, 1'b0};
    if (v > 3999) return {12'd3999, 1'b0};
`else
    if (v < 2000 || v > 3999) return {12'd0, 1'b1};
`endif
    return {12'(v), 1'b0};
  endfunction

  // Drive one conversion at a negedge, check latency, hold behaviour and handshake.
  task automatic run_one(input logic [15:0] d, input int hold);
    int n;
    logic [12:0] exp_v;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready_before_accept", in_ready, 1);
    {d_thou, d_hund, d_tens, d_ones} = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {d_thou, d_hund, d_tens, d_ones} = 16'($urandom_range(0, 65535));
    @(negedge clk);
    check("in_ready_after_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("latency", n, 5);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
    check("year", year, exp_v[12:1]);
    check("err", err, exp_v[0]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      {d_thou, d_hund, d_tens, d_ones} = 16'($urandom_range(0, 65535));
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_year", year, exp_v[12:1]);
      check("hold_err", err, exp_v[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("year_kept_after_hs", year, exp_v[12:1]);
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic [15:0] d;
    int y;
    vecs[0] = '{16'h2024, 0, 12'd2024, 1'b0};
    vecs[1] = '{16'h3999, 0, 12'd3999, 1'b0};
    vecs[2] = '{16'h2000, 0, 12'd2000, 1'b0};
`ifdef BCD_YEAR_CLAMP_EN
    vecs[3] = '{16'h1999, 0, 12'd2000, 1'b0};
    vecs[4] = '{16'h4000, 0, 12'd3999, 1'b0};
    vecs[7] = '{16'h0000, 1, 12'd2000, 1'b0};
    vecs[8] = '{16'h9999, 2, 12'd3999, 1'b0};
`else
    vecs[3] = '{16'h1999, 0, 12'd0, 1'b1};
    vecs[4] = '{16'h4000, 0, 12'd0, 1'b1};
    vecs[7] = '{16'h0000, 1, 12'd0, 1'b1};
    vecs[8] = '{16'h9999, 2, 12'd0, 1'b1};
`endif
    vecs[5] = '{16'h20A1, 0, 12'd0, 1'b1};
    vecs[6] = '{16'h2024, 10, 12'd2024, 1'b0};
    vecs[9] = '{16'hF999, 0, 12'd0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    {d_thou, d_hund, d_tens, d_ones} = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_year", year, 0);
    check("reset_err", err, 0);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].y, vecs[i].e});
      run_one(vecs[i].digits, vecs[i].hold);
    end

    // Reset at E2 aborts a conversion; the partial result never appears.
    {d_thou, d_hund, d_tens, d_ones} = 16'h2345;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_year", year, 0);
    check("abort_err", err, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_output", out_valid, 0);
    end
    exp_q.push_back({12'd2100, 1'b0});
    run_one(16'h2100, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom_range(0, 65535));
      end else begin
        y = $urandom_range(1900, 4100);
        d = {4'(y / 1000 % 10), 4'(y / 100 % 10), 4'(y / 10 % 10), 4'(y % 10)};
      end
      exp_q.push_back(ref_year(d));
      run_one(d, $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
